// File: rtl/fifo_uart_tx.sv
// Serial drain stage for the 6-bit FIFO: pops one word at a time and sends it
// LSB-first as start bit, data bits, optional even parity, stop bit.
module fifo_uart_tx #(
   parameter int unsigned DATA_W       = 6,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              fifo_empty_n,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              wr_active,
   output logic              fifo_pop,
   output logic              tx,
   output logic              busy
);

   localparam int unsigned     CNT_W    = 8;
   localparam int unsigned     BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

   state_t            state, state_nx;
   logic [DATA_W-1:0] shift, shift_nx;
   logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
   logic [CNT_W-1:0]  clk_cnt, clk_cnt_nx;
   logic              par, par_nx;
   logic              tx_nx, pop_nx, busy_nx;
   logic              bit_end;

   assign bit_end = (clk_cnt == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         shift    <= '0;
         bit_cnt  <= '0;
         clk_cnt  <= '0;
         par      <= 1'b0;
         tx       <= 1'b1;
         fifo_pop <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         shift    <= shift_nx;
         bit_cnt  <= bit_cnt_nx;
         clk_cnt  <= clk_cnt_nx;
         par      <= par_nx;
         tx       <= tx_nx;
         fifo_pop <= pop_nx;
         busy     <= busy_nx;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_nx   = state;
      shift_nx   = shift;
      bit_cnt_nx = bit_cnt;
      clk_cnt_nx = clk_cnt;
      par_nx     = par;
      tx_nx      = tx;
      pop_nx     = fifo_pop;
      busy_nx    = busy;

      // Every serial bit lasts CLKS_PER_BIT cycles; counter wraps on the boundary
      if (state == START || state == DATA || state == PARITY || state == STOP) begin
         clk_cnt_nx = bit_end ? '0 : clk_cnt + CNT_W'(1);
      end

      case (state)
         IDLE: begin
            if (enable && fifo_empty_n) begin
               state_nx = POP;
               pop_nx   = 1'b1;
               busy_nx  = 1'b1;
            end
         end
         POP: begin
            if (!wr_active) begin
               state_nx = LOAD;
               pop_nx   = 1'b0;
            end
         end
         LOAD: begin
            shift_nx   = fifo_data;
            par_nx     = ^fifo_data;
            tx_nx      = 1'b0;
            clk_cnt_nx = '0;
            bit_cnt_nx = '0;
            state_nx   = START;
         end
         START: begin
            if (bit_end) begin
               tx_nx    = shift[0];
               shift_nx = shift >> 1;
               state_nx = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
                  bit_cnt_nx = '0;
                  if (PARITY_EN) begin
                     tx_nx    = par;
                     state_nx = PARITY;
                  end else begin
                     tx_nx    = 1'b1;
                     state_nx = STOP;
                  end
               end else begin
                  bit_cnt_nx = bit_cnt + BIT_W'(1);
                  tx_nx      = shift[0];
                  shift_nx   = shift >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               tx_nx    = 1'b1;
               state_nx = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
         end
         default: begin
            tx_nx    = 1'b1;
            pop_nx   = 1'b0;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO sources, table-driven frame vectors
// and hand-written back-to-back, enable and mid-frame reset sequences.
module tb_fifo_uart_tx;

   localparam int unsigned DW     = 6;
   localparam int          C      = 4;
   localparam int          TR_MAX = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, enable, wr_active;
   logic [3:0]    wr_a = '0, rd_a = '0, wr_p = '0, rd_p = '0;
   logic [DW-1:0] mem_a [16];
   logic [DW-1:0] mem_p [16];
   logic [DW-1:0] data_a = '0, data_p = '0;
   logic          empty_n_a, empty_n_p;
   logic          pop_a, tx_a, busy_a, pop_p, tx_p, busy_p;

   assign empty_n_a = (wr_a != rd_a);
   assign empty_n_p = (wr_p != rd_p);

   fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty_n(empty_n_a),
      .fifo_data(data_a), .wr_active(wr_active),
      .fifo_pop(pop_a), .tx(tx_a), .busy(busy_a));

   fifo_uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut_p (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty_n(empty_n_p),
      .fifo_data(data_p), .wr_active(wr_active),
      .fifo_pop(pop_p), .tx(tx_p), .busy(busy_p));

   // FIFO read side: data appears the cycle after an accepted pop
   always @(posedge clk) begin
      if (pop_a && !wr_active && empty_n_a) begin
         data_a <= mem_a[rd_a];
         rd_a   <= rd_a + 4'd1;
      end
      if (pop_p && !wr_active && empty_n_p) begin
         data_p <= mem_p[rd_p];
         rd_p   <= rd_p + 4'd1;
      end
   end

   logic tr_pop [TR_MAX];
   logic tr_tx  [TR_MAX];
   logic tr_busy[TR_MAX];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input logic sel, input logic [DW-1:0] w);
      if (sel) begin
         mem_p[wr_p] = w;
         wr_p        = wr_p + 4'd1;
      end else begin
         mem_a[wr_a] = w;
         wr_a        = wr_a + 4'd1;
      end
   endtask

   // Record n cycles of outputs; stalls the pop, drops enable or pulses reset on request
   task automatic trace(input int n, input logic sel, input int stall,
                        input int drop_en_at, input int rst_at);
      int left;
      left = stall;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         tr_pop[i]  = sel ? pop_p  : pop_a;
         tr_tx[i]   = sel ? tx_p   : tx_a;
         tr_busy[i] = sel ? busy_p : busy_a;
         if (i == drop_en_at) enable = 1'b0;
         reset_n = (i == rst_at) ? 1'b0 : 1'b1;
         if (tr_pop[i] && left > 0) begin
            wr_active = 1'b1;
            left--;
         end else begin
            wr_active = 1'b0;
         end
      end
   endtask

   function automatic int first_fall(input int from, input int n);
      for (int i = from; i < n; i++) if (tr_tx[i] == 1'b0) return i;
      return -1;
   endfunction

   function automatic int count_pop(input int from, input int n);
      int c = 0;
      for (int i = from; i < n; i++) if (tr_pop[i]) c++;
      return c;
   endfunction

   function automatic int count_busy(input int from, input int n);
      int c = 0;
      for (int i = from; i < n; i++) if (tr_busy[i]) c++;
      return c;
   endfunction

   function automatic int count_tx_hi(input int from, input int n);
      int c = 0;
      for (int i = from; i < n; i++) if (tr_tx[i]) c++;
      return c;
   endfunction

   // exp holds the frame in time order from bit 9 downward
   task automatic check_bits(input string name, input int f, input int nbits, input logic [9:0] exp);
      int         base;
      logic [3:0] got;
      base = (f < 0) ? 0 : f;
      for (int k = 0; k < nbits; k++) begin
         for (int j = 0; j < C; j++) begin
            int idx = base + k * C + j;
            got[C-1-j] = (idx < TR_MAX) ? tr_tx[idx] : 1'bx;
         end
         chk($sformatf("%s bit%0d", name, k), 32'(got), exp[9-k] ? 32'hF : 32'h0);
      end
   endtask

   typedef struct {
      logic [DW-1:0] word;
      int            stall;
      logic          par;
      int            nbits;
      logic [9:0]    exp;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int    f, f2;
      string nm;

      vecs[0] = '{6'h2A, 0, 1'b0, 8, 10'b0_010101_1_00};
      vecs[1] = '{6'h25, 0, 1'b0, 8, 10'b0_101001_1_00};
      vecs[2] = '{6'h2C, 3, 1'b0, 8, 10'b0_001101_1_00};
      vecs[3] = '{6'h3F, 1, 1'b0, 8, 10'b0_111111_1_00};
      vecs[4] = '{6'h15, 0, 1'b1, 9, 10'b0_101010_1_1_0};
      vecs[5] = '{6'h03, 0, 1'b1, 9, 10'b0_110000_0_1_0};
      vecs[6] = '{6'h00, 0, 1'b1, 9, 10'b0_000000_0_1_0};

      reset_n   = 1'b0;
      enable    = 1'b0;
      wr_active = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset tx",   32'(tx_a),   32'h1);
      chk("reset busy", 32'(busy_a), 32'h0);
      chk("reset pop",  32'(pop_a),  32'h0);
      chk("reset tx_p",   32'(tx_p),   32'h1);
      chk("reset busy_p", 32'(busy_p), 32'h0);
      chk("reset pop_p",  32'(pop_p),  32'h0);
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (2) @(posedge clk);

      // Single-frame vectors
      for (int i = 0; i < 7; i++) begin
         nm = $sformatf("v%0d", i);
         @(negedge clk);
         push(vecs[i].par, vecs[i].word);
         trace(50, vecs[i].par, vecs[i].stall, -1, -1);
         f = first_fall(0, 50);
         chk({nm, " first pop"}, 32'(tr_pop[0]), 32'h1);
         chk({nm, " latency"}, 32'(f), 32'(2 + vecs[i].stall));
         chk({nm, " lead tx high"}, 32'(count_tx_hi(0, 2 + vecs[i].stall)), 32'(2 + vecs[i].stall));
         chk({nm, " pop cycles"}, 32'(count_pop(0, 50)), 32'(1 + vecs[i].stall));
         check_bits(nm, f, vecs[i].nbits, vecs[i].exp);
         chk({nm, " busy cycles"}, 32'(count_busy(0, 50)), 32'(2 + vecs[i].stall + vecs[i].nbits * C));
         chk({nm, " end idle tx"}, 32'(tr_tx[49]), 32'h1);
      end

      // Back-to-back words 0x01, 0x3F
      @(negedge clk);
      push(1'b0, 6'h01);
      push(1'b0, 6'h3F);
      trace(80, 1'b0, 0, -1, -1);
      f = first_fall(0, 80);
      chk("b2b latency1", 32'(f), 32'd2);
      check_bits("b2b f1", f, 8, 10'b0_100000_1_00);
      chk("b2b busy33", 32'(tr_busy[33]), 32'h1);
      chk("b2b idle gap", 32'(tr_busy[34]), 32'h0);
      chk("b2b gap tx", 32'(tr_tx[34]), 32'h1);
      chk("b2b pop2", 32'(tr_pop[35]), 32'h1);
      f2 = first_fall(36, 80);
      chk("b2b latency2", 32'(f2), 32'd37);
      check_bits("b2b f2", f2, 8, 10'b0_111111_1_00);
      chk("b2b pops", 32'(count_pop(0, 80)), 32'd2);
      chk("b2b busy total", 32'(count_busy(0, 80)), 32'd68);
      chk("b2b fifo empty", 32'(empty_n_a), 32'h0);

      // enable low blocks pops; dropping it mid-frame lets the frame finish
      enable = 1'b0;
      @(negedge clk);
      push(1'b0, 6'h2A);
      push(1'b0, 6'h3F);
      trace(20, 1'b0, 0, -1, -1);
      chk("en0 no pop", 32'(count_pop(0, 20)), 32'd0);
      chk("en0 no busy", 32'(count_busy(0, 20)), 32'd0);
      enable = 1'b1;
      trace(80, 1'b0, 0, 10, -1);
      f = first_fall(0, 80);
      chk("en drop latency", 32'(f), 32'd2);
      check_bits("en drop", f, 8, 10'b0_010101_1_00);
      chk("en drop pops", 32'(count_pop(0, 80)), 32'd1);
      chk("en drop busy", 32'(count_busy(0, 80)), 32'd34);
      chk("en drop pending", 32'(empty_n_a), 32'h1);
      enable = 1'b1;
      trace(50, 1'b0, 0, -1, -1);
      chk("en1 pop", 32'(tr_pop[0]), 32'h1);
      f = first_fall(0, 50);
      check_bits("en1", f, 8, 10'b0_111111_1_00);
      chk("en1 pops", 32'(count_pop(0, 50)), 32'd1);

      // Reset during data bit 2 (samples 14..17)
      @(negedge clk);
      push(1'b0, 6'h2A);
      trace(40, 1'b0, 0, -1, 15);
      chk("rst mid bit2", 32'(tr_tx[15]), 32'h0);
      chk("rst mid busy", 32'(tr_busy[15]), 32'h1);
      chk("rst tx", 32'(tr_tx[16]), 32'h1);
      chk("rst busy", 32'(tr_busy[16]), 32'h0);
      chk("rst pop", 32'(tr_pop[16]), 32'h0);
      chk("rst pops", 32'(count_pop(0, 40)), 32'd1);
      trace(60, 1'b0, 0, -1, -1);
      chk("post rst pops", 32'(count_pop(0, 60)), 32'd0);
      chk("post rst busy", 32'(count_busy(0, 60)), 32'd0);
      chk("post rst tx", 32'(count_tx_hi(0, 60)), 32'd60);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial drain stage that sits directly downstream of the 6-bit FIFO. It watches the FIFO's not-empty flag, pops one word using the FIFO's pop/registered-data protocol, and transmits it LSB-first as an asynchronous serial frame: start bit, data bits, optional even parity, stop bit. It converts the FIFO's parallel head-of-queue output into a single pin, so buffered words can leave the chip at a fixed bit rate.

## Interface
Parameters:
- DATA_W, 6: word width; matches the FIFO data width.
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal range 1..255.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  permits new frames to start; sampled only in IDLE.
- fifo_empty_n  in  1  FIFO not-empty flag.
- fifo_data  in  DATA_W  FIFO registered data output; shows the popped word the cycle after the pop edge.
- wr_active  in  1  FIFO is in write mode this cycle, so a pop is ignored by the FIFO.
- fifo_pop  out  1  pop request to the FIFO; registered.
- tx  out  1  serial line; idle high; registered.
- busy  out  1  high in every state except IDLE; registered.

## Operation
- Reset: state=IDLE, tx=1, fifo_pop=0, busy=0, shift register=0, bit and clock counters=0.
- States: IDLE, POP, LOAD, START, DATA, PARITY (only if PARITY_EN), STOP.
- IDLE: if enable && fifo_empty_n, go to POP and set fifo_pop=1. Otherwise stay in IDLE.
- POP: the pop is accepted at an edge where fifo_pop=1 and wr_active=0. On acceptance, go to LOAD and set fifo_pop=0. While wr_active=1, stay in POP with fifo_pop held at 1 (stall); there is no timeout.
- LOAD: shift register <= fifo_data; go to START; tx <= 0.
- START, DATA, PARITY and STOP each last exactly CLKS_PER_BIT cycles. The clock counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- DATA: tx drives shift[0], and the register shifts right on each bit boundary. The bit counter runs 0..DATA_W-1; after bit DATA_W-1, go to PARITY or STOP.
- PARITY: tx = XOR of the DATA_W bits loaded, which gives even parity over data plus the parity bit.
- STOP: tx=1. At the end of the stop bit, go to IDLE.
- enable going low mid-frame does not abort the frame. It only blocks the next IDLE->POP transition.
- fifo_empty_n is ignored outside IDLE. A word written during a frame is popped after the return to IDLE.
- Reset asserted in any state returns to reset values on the next edge. A word already popped is discarded, and the FIFO is not re-popped.

## Timing
- Pop edge: the edge with fifo_pop=1 and wr_active=0. fifo_data is captured at the next edge, the LOAD edge. tx falls on that same LOAD edge.
- Latency from the IDLE edge that sees fifo_empty_n=1 to tx falling is 2 cycles when not stalled; each wr_active stall cycle adds 1.
- Frame length on tx is (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles.
- busy-high duration is frame length + 2 cycles (POP, LOAD) + stall cycles. busy rises with fifo_pop and falls on the edge leaving STOP.
- Back-to-back: at least 1 IDLE cycle, during which tx=1 and busy=0, separates frames. With CLKS_PER_BIT=4 and no parity, the period is 35 cycles.
- fifo_pop is never high for a cycle in which wr_active=0 more than once per word.

## Test plan
- Single word, CLKS_PER_BIT=4, no parity: FIFO holds 0x2A. Required: fifo_pop high 1 cycle; tx=1 during IDLE/POP/LOAD; tx falls on the LOAD edge; then tx = 0 (start), 0,1,0,1,0,1, then 1 (stop), each bit 4 cycles wide; busy high 34 cycles.
- Back-to-back: FIFO holds 0x01 then 0x3F. Required: two frames, data 1,0,0,0,0,0 then 1,1,1,1,1,1; exactly 1 idle cycle with busy=0 between frames; fifo_empty_n low after the second pop; no third pop.
- Pop stall: hold wr_active=1 for 3 cycles starting with POP. Required: fifo_pop held high for 4 cycles; start bit delayed by 3 cycles; the transmitted word equals the FIFO head at acceptance.
- Parity, PARITY_EN=1: word 0x15. Required: data bits 1,0,1,0,1,0; parity bit 1; stop bit 1; frame length 36 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert reset_n=0 during data bit 2. Required: next edge tx=1, busy=0, fifo_pop=0. After release with the FIFO empty, the block stays idle indefinitely.
- enable low: FIFO non-empty with enable=0 gives no pop. Dropping enable mid-frame lets the frame complete, and no new pop follows until enable=1.
